dm_port_arb: RTL and testbench

//  Arbitrates the single data-memory port between the program sequencer (DM<->ureg, DM-immediate
//  and immediate-address accesses) and a DMA/host requester. The PS has priority. A starvation

---
 rtl/dm_port_arb_pkg.sv | 26 ++
 rtl/dm_port_arb_if.sv | 48 ++++
 rtl/dm_port_arb_starve_ctr.sv | 27 ++
 rtl/dm_port_arb.sv | 121 ++++++++++++
 tb/tb_dm_port_arb.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/dm_port_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states and grant-source encoding.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PS_ACC  = 2'd1,
    DMA_ACC = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PS   = 2'd1,
    SRC_DMA  = 2'd2
  } grant_src_e;

  function automatic arb_state_e src_to_state(grant_src_e src);
    arb_state_e st;
    case (src)
      SRC_PS:  st = PS_ACC;
      SRC_DMA: st = DMA_ACC;
      default: st = IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/dm_port_arb_if.sv
// Bus bundle around the DM port arbiter: PS side, DMA side and DM macro side.
interface dm_port_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          ps_dm_cslt;
  logic          ps_dm_wrb;
  logic [AW-1:0] dg_dm_add;
  logic [DW-1:0] bc_dm_dt;
  logic          stallb;
  logic [DW-1:0] dm_bc_dt;
  logic          dm_bc_vld;

  logic          dma_req;
  logic          dma_wrb;
  logic [AW-1:0] dma_add;
  logic [DW-1:0] dma_wdt;
  logic          dma_gnt;
  logic          dma_rvld;
  logic [DW-1:0] dma_rdt;

  logic          dm_cslt;
  logic          dm_wrb;
  logic [AW-1:0] dm_add;
  logic [DW-1:0] dm_wdt;
  logic [DW-1:0] dm_rdt;

  // requesters and the DM macro model
  modport master (
    output ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dm_dt,
    output dma_req, dma_wrb, dma_add, dma_wdt,
    output dm_rdt,
    input  stallb, dm_bc_dt, dm_bc_vld,
    input  dma_gnt, dma_rvld, dma_rdt,
    input  dm_cslt, dm_wrb, dm_add, dm_wdt
  );

  // the arbiter itself
  modport slave (
    input  ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dm_dt,
    input  dma_req, dma_wrb, dma_add, dma_wdt,
    input  dm_rdt,
    output stallb, dm_bc_dt, dm_bc_vld,
    output dma_gnt, dma_rvld, dma_rdt,
    output dm_cslt, dm_wrb, dm_add, dm_wdt
  );

endinterface

// File: rtl/dm_port_arb_starve_ctr.sv
// Saturating count of consecutive denied DMA-request cycles; full forces a DMA slot.
module dm_arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic full
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign full = (cnt == W'(MAX));

endmodule

// File: rtl/dm_port_arb.sv
// Data-memory port arbiter: PS has priority, DMA gets a forced slot after STARVE_MAX denials.
//   state   | meaning
//   IDLE    | port unused, any request is granted at the next edge
//   PS_ACC  | PS access in flight, acc_cnt counts its cycles
//   DMA_ACC | DMA access in flight, acc_cnt counts its cycles
module dm_port_arb
  import dm_arb_pkg::*;
#(
  parameter int ACC_CYC    = 1,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 16,
  parameter int DW         = 16
) (
  input logic          clk,
  input logic          rst,
  dm_port_arb_if.slave bus
);
  localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_CYC - 1);

  arb_state_e    state, next_state;
  grant_src_e    src;
  logic [CW-1:0] acc_cnt;
  logic          slot_free;
  logic          force_dma;
  logic          starve_full;
  logic          dma_gnt;
  logic          stallb;

  logic          dm_cslt, dm_wrb;
  logic [AW-1:0] dm_add;
  logic [DW-1:0] dm_wdt;
  logic [DW-1:0] dm_bc_dt, dma_rdt;
  logic          dm_bc_vld, dma_rvld;

  dm_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk  (clk),
    .rst  (rst),
    .clr  (dma_gnt | ~bus.dma_req),
    .inc  (bus.dma_req),
    .full (starve_full)
  );

  always_comb begin
    slot_free  = (state == IDLE) || (acc_cnt == LAST);
    force_dma  = bus.dma_req & starve_full;
    src        = SRC_NONE;
    if (force_dma)           src = SRC_DMA;
    else if (bus.ps_dm_cslt) src = SRC_PS;
    else if (bus.dma_req)    src = SRC_DMA;
    next_state = state;
    if (slot_free) next_state = src_to_state(src);
    stallb  = ~(bus.ps_dm_cslt & ~(slot_free & ~force_dma));
    dma_gnt = slot_free & bus.dma_req & (force_dma | ~bus.ps_dm_cslt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // dm_wrb still describes the access that is ending when slot_free is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt   <= '0;
      dm_cslt   <= 1'b0;
      dm_wrb    <= 1'b1;
      dm_add    <= '0;
      dm_wdt    <= '0;
      dm_bc_dt  <= '0;
      dm_bc_vld <= 1'b0;
      dma_rdt   <= '0;
      dma_rvld  <= 1'b0;
    end else begin
      dm_bc_vld <= 1'b0;
      dma_rvld  <= 1'b0;
      if (slot_free) begin
        acc_cnt <= '0;
        if ((state == PS_ACC) && dm_wrb) begin
          dm_bc_dt  <= bus.dm_rdt;
          dm_bc_vld <= 1'b1;
        end else if ((state == DMA_ACC) && dm_wrb) begin
          dma_rdt  <= bus.dm_rdt;
          dma_rvld <= 1'b1;
        end
        case (src)
          SRC_PS: begin
            dm_cslt <= 1'b1;
            dm_wrb  <= bus.ps_dm_wrb;
            dm_add  <= bus.dg_dm_add;
            dm_wdt  <= bus.bc_dm_dt;
          end
          SRC_DMA: begin
            dm_cslt <= 1'b1;
            dm_wrb  <= bus.dma_wrb;
            dm_add  <= bus.dma_add;
            dm_wdt  <= bus.dma_wdt;
          end
          default: begin
            dm_cslt <= 1'b0;
            dm_wrb  <= 1'b1;
          end
        endcase
      end else begin
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

  assign bus.stallb    = stallb;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.dm_cslt   = dm_cslt;
  assign bus.dm_wrb    = dm_wrb;
  assign bus.dm_add    = dm_add;
  assign bus.dm_wdt    = dm_wdt;
  assign bus.dm_bc_dt  = dm_bc_dt;
  assign bus.dm_bc_vld = dm_bc_vld;
  assign bus.dma_rdt   = dma_rdt;
  assign bus.dma_rvld  = dma_rvld;

endmodule

// File: tb/tb_dm_port_arb.sv
// Directed bench for dm_port_arb: one instance with ACC_CYC=1, one with ACC_CYC=3.
module tb_dm_port_arb;
  import dm_arb_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  dm_port_arb_if #(.AW(16), .DW(16)) b1 ();
  dm_port_arb_if #(.AW(16), .DW(16)) b3 ();

  dm_port_arb #(.ACC_CYC(1), .STARVE_MAX(4), .AW(16), .DW(16)) u1 (
    .clk (clk), .rst (rst), .bus (b1.slave));
  dm_port_arb #(.ACC_CYC(3), .STARVE_MAX(4), .AW(16), .DW(16)) u3 (
    .clk (clk), .rst (rst), .bus (b3.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    b1.ps_dm_cslt = 0; b1.ps_dm_wrb = 1; b1.dg_dm_add = '0; b1.bc_dm_dt = '0;
    b1.dma_req = 0; b1.dma_wrb = 1; b1.dma_add = '0; b1.dma_wdt = '0; b1.dm_rdt = '0;
    b3.ps_dm_cslt = 0; b3.ps_dm_wrb = 1; b3.dg_dm_add = '0; b3.bc_dm_dt = '0;
    b3.dma_req = 0; b3.dma_wrb = 1; b3.dma_add = '0; b3.dma_wdt = '0; b3.dm_rdt = '0;

    // 1. reset
    tick(); tick();
    chk("rst_cslt1", 32'(b1.dm_cslt), 32'd0);
    chk("rst_wrb1", 32'(b1.dm_wrb), 32'd1);
    chk("rst_stallb1", 32'(b1.stallb), 32'd1);
    chk("rst_vld1", 32'({b1.dm_bc_vld, b1.dma_rvld, b1.dma_gnt}), 32'd0);
    chk("rst_cslt3", 32'(b3.dm_cslt), 32'd0);
    chk("rst_add3", 32'(b3.dm_add), 32'd0);
    rst = 1'b1;

    // 2. PS-only read, ACC_CYC=1
    tick();
    b1.ps_dm_cslt = 1; b1.ps_dm_wrb = 1; b1.dg_dm_add = 16'h0040; b1.dm_rdt = 16'hBEEF;
    #1 chk("t2_stallb", 32'(b1.stallb), 32'd1);
    tick();
    b1.ps_dm_cslt = 0;
    #1 chk("t2_cslt", 32'(b1.dm_cslt), 32'd1);
    chk("t2_add", 32'(b1.dm_add), 32'h0040);
    chk("t2_novld", 32'(b1.dm_bc_vld), 32'd0);
    tick();
    chk("t2_vld", 32'(b1.dm_bc_vld), 32'd1);
    chk("t2_dt", 32'(b1.dm_bc_dt), 32'hBEEF);
    chk("t2_cslt_off", 32'(b1.dm_cslt), 32'd0);
    chk("t2_wrb_idle", 32'(b1.dm_wrb), 32'd1);
    tick();
    chk("t2_vld_pulse", 32'(b1.dm_bc_vld), 32'd0);

    // 3. PS streams writes while DMA read waits for its forced slot
    b1.ps_dm_cslt = 1; b1.ps_dm_wrb = 0; b1.dg_dm_add = 16'h0041; b1.bc_dm_dt = 16'h0A0A;
    b1.dma_req = 1; b1.dma_wrb = 1; b1.dma_add = 16'h0200; b1.dm_rdt = 16'hCAFE;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("t3_nogrant%0d", i), 32'(b1.dma_gnt), 32'd0);
      chk($sformatf("t3_nostall%0d", i), 32'(b1.stallb), 32'd1);
      tick();
    end
    #1 chk("t3_gnt", 32'(b1.dma_gnt), 32'd1);
    chk("t3_stall", 32'(b1.stallb), 32'd0);
    tick();
    b1.dma_req = 0;
    #1 chk("t3_dma_add", 32'(b1.dm_add), 32'h0200);
    chk("t3_dma_wrb", 32'(b1.dm_wrb), 32'd1);
    chk("t3_starve_clr", 32'(u1.u_starve.cnt), 32'd0);
    chk("t3_resume_stallb", 32'(b1.stallb), 32'd1);
    tick();
    b1.ps_dm_cslt = 0;
    #1 chk("t3_ps_add", 32'(b1.dm_add), 32'h0041);
    chk("t3_ps_wrb", 32'(b1.dm_wrb), 32'd0);
    chk("t3_rvld", 32'(b1.dma_rvld), 32'd1);
    chk("t3_rdt", 32'(b1.dma_rdt), 32'hCAFE);
    chk("t3_no_psvld", 32'(b1.dm_bc_vld), 32'd0);
    tick();
    chk("t3_idle_cslt", 32'(b1.dm_cslt), 32'd0);
    chk("t3_rvld_pulse", 32'(b1.dma_rvld), 32'd0);

    // 4. ACC_CYC=3: DMA write, then PS read request in its first cycle
    b3.dma_req = 1; b3.dma_wrb = 0; b3.dma_add = 16'h0100; b3.dma_wdt = 16'h1234;
    #1 chk("t4_gnt", 32'(b3.dma_gnt), 32'd1);
    tick();
    b3.dma_req = 0;
    b3.ps_dm_cslt = 1; b3.ps_dm_wrb = 1; b3.dg_dm_add = 16'h0050;
    #1 chk("t4_c1_cslt", 32'(b3.dm_cslt), 32'd1);
    chk("t4_add", 32'(b3.dm_add), 32'h0100);
    chk("t4_wdt", 32'(b3.dm_wdt), 32'h1234);
    chk("t4_wrb", 32'(b3.dm_wrb), 32'd0);
    chk("t4_c1_stall", 32'(b3.stallb), 32'd0);
    tick();
    chk("t4_c2_cslt", 32'(b3.dm_cslt), 32'd1);
    chk("t4_c2_stall", 32'(b3.stallb), 32'd0);
    tick();
    b3.dm_rdt = 16'h5A5A;
    #1 chk("t4_c3_cslt", 32'(b3.dm_cslt), 32'd1);
    chk("t4_c3_stallb", 32'(b3.stallb), 32'd1);
    tick();
    b3.ps_dm_cslt = 0;
    #1 chk("t4_ps_cslt", 32'(b3.dm_cslt), 32'd1);
    chk("t4_ps_add", 32'(b3.dm_add), 32'h0050);
    chk("t4_ps_wrb", 32'(b3.dm_wrb), 32'd1);
    chk("t4_wr_norvld", 32'(b3.dma_rvld), 32'd0);
    tick();
    tick();
    chk("t4_ps_novld_yet", 32'(b3.dm_bc_vld), 32'd0);
    tick();
    chk("t4_ps_vld", 32'(b3.dm_bc_vld), 32'd1);
    chk("t4_ps_dt", 32'(b3.dm_bc_dt), 32'h5A5A);
    chk("t4_ps_done", 32'(b3.dm_cslt), 32'd0);

    // 5. ACC_CYC=3 DMA read with no PS request
    tick();
    b3.dma_req = 1; b3.dma_wrb = 1; b3.dma_add = 16'h0300;
    #1 chk("t5_gnt", 32'(b3.dma_gnt), 32'd1);
    tick();
    b3.dma_req = 0; b3.dm_rdt = 16'h7777;
    tick();
    tick();
    chk("t5_norvld_yet", 32'(b3.dma_rvld), 32'd0);
    tick();
    chk("t5_rvld", 32'(b3.dma_rvld), 32'd1);
    chk("t5_rdt", 32'(b3.dma_rdt), 32'h7777);
    chk("t5_no_psvld", 32'(b3.dm_bc_vld), 32'd0);

    // 6. reset in the second cycle of an ACC_CYC=3 PS read
    tick();
    b3.ps_dm_cslt = 1; b3.ps_dm_wrb = 1; b3.dg_dm_add = 16'h0060; b3.dm_rdt = 16'h1111;
    tick();
    b3.ps_dm_cslt = 0;
    tick();
    #1 chk("t6_pre_cslt", 32'(b3.dm_cslt), 32'd1);
    rst = 1'b0;
    #1 chk("t6_abort_cslt", 32'(b3.dm_cslt), 32'd0);
    chk("t6_abort_wrb", 32'(b3.dm_wrb), 32'd1);
    tick();
    chk("t6_rst_vld", 32'({b3.dm_bc_vld, b3.dma_rvld}), 32'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("t6_state_idle", 32'(u3.state), 32'(IDLE));
    chk("t6_post_vld", 32'({b3.dm_bc_vld, b3.dma_rvld}), 32'd0);
    chk("t6_post_cslt", 32'(b3.dm_cslt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
